// File: rtl/fp_sink_pkg.sv
// Shared widths, flag bit positions and the FIFO entry layout for the
// floating-point result sink.
package fp_sink_pkg;

  localparam int SP_WIDTH    = 32;
  localparam int EXP_WIDTH   = 8;
  localparam int MAN_WIDTH   = 23;
  localparam int SEQ_WIDTH   = 8;
  localparam int FLAG_WIDTH  = 4;
  localparam int ENTRY_WIDTH = SEQ_WIDTH + FLAG_WIDTH + SP_WIDTH;

  localparam int NAN = 3;
  localparam int INV = 2;
  localparam int OVF = 1;
  localparam int UNF = 0;

  typedef struct packed {
    logic [SEQ_WIDTH-1:0]  seq;
    logic [FLAG_WIDTH-1:0] flags;
    logic [SP_WIDTH-1:0]   data;
  } entry_t;

  // Quiet or signalling NaN: all-ones exponent with a non-zero mantissa.
  function automatic logic is_nan(input logic [SP_WIDTH-1:0] y);
    return (y[SP_WIDTH-2 -: EXP_WIDTH] == {EXP_WIDTH{1'b1}}) &&
           (y[MAN_WIDTH-1:0] != '0);
  endfunction

endpackage

// File: rtl/fp_sink_fifo.sv
// First-word-fall-through FIFO with registered occupancy; the head word reads
// as zero whenever the FIFO is empty.
module fp_sink_fifo #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic                       rd_valid_o,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign rd_valid_o = (count_q != '0);
  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign count_o    = count_q;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign do_pop  = pop_i && rd_valid_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = rd_valid_o ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fp_result_sink.sv
// Captures filter results into a tagged FIFO, classifies NaNs at push time and
// keeps sticky drop and saturating exception counters.
module fp_result_sink
  import fp_sink_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       dv_i,
  input  logic [31:0]                y_i,
  input  logic                       invalid_i,
  input  logic                       overflow_i,
  input  logic                       underflow_i,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [31:0]                rd_data_o,
  output logic [3:0]                 rd_flags_o,
  output logic [7:0]                 rd_seq_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       drop_o,
  output logic [CNT_WIDTH-1:0]       inv_cnt_o,
  output logic [CNT_WIDTH-1:0]       ovf_cnt_o,
  output logic [CNT_WIDTH-1:0]       unf_cnt_o
);

  logic                  pop;
  logic                  push;
  logic                  drop_evt;
  logic [FLAG_WIDTH-1:0] flags_in;
  logic [SEQ_WIDTH-1:0]  seq_q;
  logic                  drop_q;
  logic [CNT_WIDTH-1:0]  inv_cnt_q;
  logic [CNT_WIDTH-1:0]  ovf_cnt_q;
  logic [CNT_WIDTH-1:0]  unf_cnt_q;
  entry_t                wr_entry;
  entry_t                rd_entry;

  assign pop      = rd_valid_o && rd_ready_i;
  assign push     = dv_i && (!full_o || pop);
  assign drop_evt = dv_i && full_o && !pop;

  always_comb begin
    flags_in      = '0;
    flags_in[NAN] = is_nan(y_i);
    flags_in[INV] = invalid_i;
    flags_in[OVF] = overflow_i;
    flags_in[UNF] = underflow_i;
  end

  assign wr_entry = '{seq: seq_q, flags: flags_in, data: y_i};

  fp_sink_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .wdata_i    (wr_entry),
    .pop_i      (pop),
    .rd_valid_o (rd_valid_o),
    .rdata_o    (rd_entry),
    .count_o    (count_o),
    .full_o     (full_o)
  );

  // Tags and counters only advance on accepted results; drops leave them alone.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seq_q     <= '0;
      drop_q    <= 1'b0;
      inv_cnt_q <= '0;
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else begin
      if (push) seq_q <= seq_q + SEQ_WIDTH'(1);
      if (drop_evt) drop_q <= 1'b1;
      if (push && flags_in[INV] && (inv_cnt_q != '1))
        inv_cnt_q <= inv_cnt_q + CNT_WIDTH'(1);
      if (push && flags_in[OVF] && (ovf_cnt_q != '1))
        ovf_cnt_q <= ovf_cnt_q + CNT_WIDTH'(1);
      if (push && flags_in[UNF] && (unf_cnt_q != '1))
        unf_cnt_q <= unf_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign rd_data_o  = rd_entry.data;
  assign rd_flags_o = rd_entry.flags;
  assign rd_seq_o   = rd_entry.seq;
  assign drop_o     = drop_q;
  assign inv_cnt_o  = inv_cnt_q;
  assign ovf_cnt_o  = ovf_cnt_q;
  assign unf_cnt_o  = unf_cnt_q;

endmodule

// File: tb/tb_fp_result_sink.sv
// Directed and randomized checks of fp_result_sink against a queue-based
// reference model.
module tb_fp_result_sink;

  localparam int DEPTH     = 8;
  localparam int CNT_WIDTH = 4;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   dv_i;
  logic [31:0]            y_i;
  logic                   invalid_i, overflow_i, underflow_i;
  logic                   rd_valid_o;
  logic                   rd_ready_i;
  logic [31:0]            rd_data_o;
  logic [3:0]             rd_flags_o;
  logic [7:0]             rd_seq_o;
  logic [$clog2(DEPTH):0] count_o;
  logic                   full_o, drop_o;
  logic [CNT_WIDTH-1:0]   inv_cnt_o, ovf_cnt_o, unf_cnt_o;

  fp_result_sink #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .dv_i(dv_i), .y_i(y_i),
    .invalid_i(invalid_i), .overflow_i(overflow_i), .underflow_i(underflow_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
    .rd_flags_o(rd_flags_o), .rd_seq_o(rd_seq_o), .count_o(count_o),
    .full_o(full_o), .drop_o(drop_o), .inv_cnt_o(inv_cnt_o),
    .ovf_cnt_o(ovf_cnt_o), .unf_cnt_o(unf_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  f;
    logic [7:0]  s;
  } ent_t;

  ent_t q[$];
  int   m_seq, m_inv, m_ovf, m_unf;
  bit   m_drop;
  int   n_vec, n_miscmp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_seq = 0; m_inv = 0; m_ovf = 0; m_unf = 0; m_drop = 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".count"}, 64'(count_o), 64'(q.size()));
    check({tag, ".valid"}, 64'(rd_valid_o), 64'(q.size() != 0));
    check({tag, ".full"},  64'(full_o), 64'(q.size() == DEPTH));
    check({tag, ".drop"},  64'(drop_o), 64'(m_drop));
    check({tag, ".inv"},   64'(inv_cnt_o), 64'(m_inv));
    check({tag, ".ovf"},   64'(ovf_cnt_o), 64'(m_ovf));
    check({tag, ".unf"},   64'(unf_cnt_o), 64'(m_unf));
    if (q.size() != 0) begin
      check({tag, ".data"},  64'(rd_data_o),  64'(q[0].d));
      check({tag, ".flags"}, 64'(rd_flags_o), 64'(q[0].f));
      check({tag, ".seq"},   64'(rd_seq_o),   64'(q[0].s));
    end else begin
      check({tag, ".data0"},  64'(rd_data_o),  64'd0);
      check({tag, ".flags0"}, 64'(rd_flags_o), 64'd0);
      check({tag, ".seq0"},   64'(rd_seq_o),   64'd0);
    end
  endtask

  // Called at posedge+1; drives one cycle, advances the model, compares.
  task automatic step(input bit dv, input logic [31:0] y, input bit inv,
                      input bit ovf, input bit unf, input bit rdy);
    bit   do_pop, do_push, nan;
    ent_t e;
    dv_i = dv; y_i = y; invalid_i = inv; overflow_i = ovf; underflow_i = unf;
    rd_ready_i = rdy;
    do_pop  = (q.size() > 0) && rdy;
    do_push = dv && ((q.size() < DEPTH) || do_pop);
    @(posedge clk_i); #1;
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      nan = (y[30:23] == 8'hFF) && (y[22:0] != 0);
      e.d = y; e.f = {nan, inv, ovf, unf}; e.s = 8'(m_seq);
      q.push_back(e);
      m_seq = (m_seq + 1) % 256;
      if (inv) m_inv = (m_inv < CNT_MAX) ? m_inv + 1 : CNT_MAX;
      if (ovf) m_ovf = (m_ovf < CNT_MAX) ? m_ovf + 1 : CNT_MAX;
      if (unf) m_unf = (m_unf < CNT_MAX) ? m_unf + 1 : CNT_MAX;
    end else if (dv) begin
      m_drop = 1;
    end
    compare_all("step");
  endtask

  // Reset pulsed between edges; outputs must clear before any clock.
  task automatic do_reset();
    dv_i = 0; rd_ready_i = 0;
    #1 rst_i = 1'b1;
    #1;
    model_reset();
    compare_all("rst_now");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 4))
      0: v[30:23] = 8'hFF;
      1: v = {v[31], 8'hFF, 23'd0};
      2: v = {v[31], 31'd0};
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    n_vec = 0; n_miscmp = 0;
    rst_i = 1'b1; dv_i = 0; y_i = 0; invalid_i = 0; overflow_i = 0;
    underflow_i = 0; rd_ready_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    compare_all("reset");
    rst_i = 1'b0;

    // Single push
    step(1, 32'h3F800000, 0, 0, 0, 0);
    check("single.valid", 64'(rd_valid_o), 64'd1);
    check("single.data",  64'(rd_data_o), 64'h3F800000);
    check("single.flags", 64'(rd_flags_o), 64'd0);
    check("single.seq",   64'(rd_seq_o), 64'd0);
    check("single.count", 64'(count_o), 64'd1);

    // NaN with invalid, then infinity
    do_reset();
    step(1, 32'h7FC00000, 1, 0, 0, 0);
    check("nan.flags", 64'(rd_flags_o), 64'b1100);
    check("nan.inv",   64'(inv_cnt_o), 64'd1);
    step(1, 32'h7F800000, 0, 0, 0, 1);
    check("inf.data",  64'(rd_data_o), 64'h7F800000);
    check("inf.nan",   64'(rd_flags_o[3]), 64'd0);

    // Fill and drop
    do_reset();
    for (int i = 0; i < 9; i++) step(1, 32'h40000000 + i, 0, 0, 0, 0);
    check("fill.full",  64'(full_o), 64'd1);
    check("fill.count", 64'(count_o), 64'd8);
    check("fill.drop",  64'(drop_o), 64'd1);
    for (int i = 0; i < 8; i++) begin
      check("fill.rdseq",  64'(rd_seq_o), 64'(i));
      check("fill.rddata", 64'(rd_data_o), 64'(32'h40000000 + i));
      step(0, 0, 0, 0, 0, 1);
    end
    check("fill.empty", 64'(rd_valid_o), 64'd0);

    // Full plus simultaneous push/pop
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 32'h41000000 + i, 0, 0, 0, 0);
    step(1, 32'h42000000, 0, 0, 0, 1);
    check("fpp.count", 64'(count_o), 64'd8);
    check("fpp.drop",  64'(drop_o), 64'd0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 1);
    check("fpp.seq8",  64'(rd_seq_o), 64'd8);
    check("fpp.data8", 64'(rd_data_o), 64'h42000000);

    // Counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) step(1, $urandom, 0, 1, 0, 1);
    check("sat.ovf", 64'(ovf_cnt_o), 64'd15);

    // Reset mid-stream
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 32'h3F000000 + i, 1, 1, 1, 0);
    do_reset();
    check("mid.valid", 64'(rd_valid_o), 64'd0);
    check("mid.count", 64'(count_o), 64'd0);
    step(1, 32'h3E000000, 0, 0, 0, 0);
    check("mid.seq0", 64'(rd_seq_o), 64'd0);

    // Randomized traffic with varying drain pressure
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int rdy_pct;
      rdy_pct = ((i / 100) % 2 == 0) ? 30 : 80;
      step($urandom_range(0, 99) < 70, rand_fp(), $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 99) < rdy_pct);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/fp_result_sink.md
FP_RESULT_SINK -- requirements
Module: fp_result_sink

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DEPTH, 8, FIFO entries; power of two, 2..64.
  CNT_WIDTH, 16, width of the saturating exception counters.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk_i        in   1                  single clock, rising edge.
  rst_i        in   1                  reset, asynchronous, active-high.
  dv_i         in   1                  filter result valid, one-cycle strobe.
  y_i          in   32                 IEEE-754 single-precision result {sign, exp[7:0], man[22:0]}.
  invalid_i    in   1                  filter invalid flag, qualified by dv_i.
  overflow_i   in   1                  filter overflow flag, qualified by dv_i.
  underflow_i  in   1                  filter underflow flag, qualified by dv_i.
  rd_valid_o   out  1                  head entry available.
  rd_ready_i   in   1                  consumer accepts the head entry.
  rd_data_o    out  32                 head result word.
  rd_flags_o   out  4                  head {nan, invalid, overflow, underflow}.
  rd_seq_o     out  8                  head sequence tag.
  count_o      out  $clog2(DEPTH)+1    current occupancy.
  full_o       out  1                  occupancy == DEPTH.
  drop_o       out  1                  sticky: a result was lost.
  inv_cnt_o    out  CNT_WIDTH          accepted results with invalid set.
  ovf_cnt_o    out  CNT_WIDTH          accepted results with overflow set.
  unf_cnt_o    out  CNT_WIDTH          accepted results with underflow set.
REQ-003 The single clock is clk_i; reset is rst_i, asynchronous, active-high.

Function
REQ-004 A push SHALL occur when dv_i=1 and either full_o=0 or a pop occurs in the same cycle.
REQ-005 A pop SHALL occur when rd_valid_o=1 and rd_ready_i=1.
REQ-006 The FIFO SHALL be first-word-fall-through: rd_valid_o, rd_data_o, rd_flags_o and rd_seq_o SHALL be valid one cycle after a push into an empty FIFO.
REQ-007 rd_valid_o SHALL equal (count_o != 0); rd_data_o, rd_flags_o and rd_seq_o SHALL remain stable while rd_valid_o=1 and rd_ready_i=0.
REQ-008 The nan flag SHALL be computed at push time: y_i[30:23]==8'hFF and y_i[22:0]!=0.
REQ-009 The sequence tag SHALL start at 0, be assigned to each pushed entry, then increment modulo 256; a dropped result SHALL NOT consume a tag.
REQ-010 dv_i=1 while full_o=1 with no pop in that cycle SHALL discard the result and set drop_o; drop_o SHALL clear only on reset.
REQ-011 Simultaneous push and pop SHALL leave count_o unchanged, in both the full and non-full states.
REQ-012 Read and write pointers SHALL wrap modulo DEPTH; count_o SHALL be registered.
REQ-013 Each exception counter SHALL increment by 1 per pushed entry whose corresponding flag is set, and SHALL saturate at all-ones.
REQ-014 Flags on dropped results SHALL NOT be counted.
REQ-015 Inputs with dv_i=0 SHALL be ignored.

Reset
REQ-016 Asserting rst_i SHALL immediately force: pointers, count_o and the sequence tag to 0; full_o, drop_o and rd_valid_o to 0; all counters to 0.
REQ-017 rd_data_o, rd_flags_o and rd_seq_o SHALL read 0 during reset and while the FIFO is empty.
REQ-018 Reset asserted mid-operation SHALL discard all stored entries, with no partial pop visible afterwards.
REQ-019 FIFO storage array contents need not be reset.

Structure
REQ-020 Package fp_sink_pkg SHALL hold SP_WIDTH=32, EXP_WIDTH=8, MAN_WIDTH=23, SEQ_WIDTH=8, and the flag bit indices NAN=3, INV=2, OVF=1, UNF=0.
REQ-021 Storage and pointers SHALL live in one sub-module, fp_sink_fifo (width 44, depth DEPTH); classification, sequencing and counters SHALL live in fp_result_sink.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  - Single push: reset, then dv_i=1, y_i=32'h3F800000, no flags, rd_ready_i=0 -> next cycle rd_valid_o=1, rd_data_o=32'h3F800000, rd_flags_o=0, rd_seq_o=0, count_o=1.
  - NaN with invalid: push y_i=32'h7FC00000 with invalid_i=1 -> rd_flags_o=4'b1100, inv_cnt_o=1; pushing 32'h7F800000 (infinity) -> nan bit 0.
  - Fill and drop: 9 consecutive pushes with DEPTH=8 and rd_ready_i=0 -> full_o=1, count_o=8, drop_o=1, entries read back with seq 0..7 and the 9th value absent.
  - Full plus simultaneous push/pop: FIFO full, rd_ready_i=1 and dv_i=1 -> count_o stays 8, drop_o stays 0, new entry takes seq 8.
  - Counter saturation: CNT_WIDTH=4, 20 pushes with overflow_i=1 and continuous drain -> ovf_cnt_o=15.
  - Reset mid-stream: 5 entries queued, rst_i pulsed between clock edges -> rd_valid_o=0, count_o=0, counters 0 immediately; next push gets seq 0.
